mem_stage: RTL and testbench

Memory-access stage of the milano core, directly downstream of `ex_stage`. It takes each result `ex_stage` produces and either forwards it to the register file or performs a load/store on the data bus. Load data is aligned and sign- or zero-extended before writeback. It back-pressures `ex_stage` while a bus transaction is outstanding and drives the register-file write port of `id_stage` (`we_i` / `waddr_i` / `wdata_i`).

---
 rtl/milano_pkg.sv | 36 +++
 rtl/lsu_data_align.sv | 58 +++++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// Shared types for the milano core memory path: operation, access size and LSU FSM state.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package milano_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } lsu_state_e;

    // Bytes never misalign; halfwords need addr[0]=0; words (and any
    // unused size encoding, treated as word) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Lane steering for the LSU: store byte enables and replication, load extraction and extension.
// Latency: purely combinational.
// Backpressure: none; the store side and load side are independent and always valid.
//
// Ports:
//   st_size/st_offset/st_wdata -> be, st_data   : store side, driven from the EX operation
//   ld_size/ld_offset/ld_unsigned/rdata -> ld_data : load side, driven from the held request
module lsu_data_align
    import milano_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        be      = 4'hF;
        st_data = st_wdata;
        case (st_size)
            SZ_B: begin
                be      = 4'b0001 << st_offset;
                st_data = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                be      = 4'b0011 << st_offset;
                st_data = {2{st_wdata[15:0]}};
            end
            default: begin
                be      = 4'hF;
                st_data = st_wdata;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then truncate and extend.
    assign shifted = rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_size)
            SZ_B: ld_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data = ld_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results or runs one load/store on the data bus, then writes rf.
// Latency: MEM_NONE/misaligned results 1 cycle after acceptance; loads >= 3 cycles to writeback.
// Backpressure: ex_ready_o is high only in IDLE, so EX stalls while a bus transaction is outstanding.
//
// Ports:
//   clk_i, rst_ni                 : core clock, asynchronous active-low reset
//   ex_*                          : operation from ex_stage (valid/ready handshake)
//   data_req_o/data_gnt_i, data_* : data-bus address phase; data_rvalid_i/rdata/err response
//   rf_we_o/rf_waddr_o/rf_wdata_o : registered one-cycle register-file write
//   lsu_err_o, misaligned_o       : one-cycle exception pulses
module mem_stage
    import milano_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ex_valid_i,
    output logic          ex_ready_o,
    input  logic [1:0]    ex_mem_op_i,
    input  logic [1:0]    ex_size_i,
    input  logic          ex_unsigned_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [31:0]   ex_wdata_i,
    input  logic [4:0]    ex_rd_addr_i,
    input  logic          ex_reg_we_i,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic [AW-1:0] data_addr_o,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [31:0]   data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [31:0]   data_rdata_i,
    input  logic          data_err_i,
    output logic          rf_we_o,
    output logic [4:0]    rf_waddr_o,
    output logic [31:0]   rf_wdata_o,
    output logic          lsu_err_o,
    output logic          misaligned_o
);

    lsu_state_e  state_q, state_d;

    logic        accept;
    logic        op_load;
    logic        op_store;
    logic        op_mem;
    logic        op_mis;

    // Request held for the whole transaction.
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic [1:0]    offset_q;
    logic          unsigned_q;
    logic [4:0]    rd_q;
    logic          load_q;

    logic [3:0]    be_new;
    logic [31:0]   st_data_new;
    logic [31:0]   ld_data;

    assign accept   = ex_valid_i && ex_ready_o;
    assign op_load  = (ex_mem_op_i == MEM_LOAD);
    assign op_store = (ex_mem_op_i == MEM_STORE);
    assign op_mem   = op_load || op_store;
    assign op_mis   = is_misaligned(ex_size_i, ex_addr_i[1:0]);

    lsu_data_align u_align (
        .st_size     (ex_size_i),
        .st_offset   (ex_addr_i[1:0]),
        .st_wdata    (ex_wdata_i),
        .be          (be_new),
        .st_data     (st_data_new),
        .ld_size     (size_q),
        .ld_offset   (offset_q),
        .ld_unsigned (unsigned_q),
        .rdata       (data_rdata_i),
        .ld_data     (ld_data)
    );

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept && op_mem && !op_mis) state_d = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i)                  state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i)               state_d = IDLE;
            default:                                      state_d = IDLE;
        endcase
    end

    // FSM: outputs. Decoded straight from state so reset drops req immediately.
    always_comb begin
        data_req_o = (state_q == WAIT_GNT);
        ex_ready_o = (state_q == IDLE);
    end

    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0;
            wdata_q      <= 32'b0;
            size_q       <= 2'b0;
            offset_q     <= 2'b0;
            unsigned_q   <= 1'b0;
            rd_q         <= 5'b0;
            load_q       <= 1'b0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= 5'b0;
            rf_wdata_o   <= 32'b0;
            lsu_err_o    <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            rf_we_o      <= 1'b0;
            lsu_err_o    <= 1'b0;
            misaligned_o <= 1'b0;

            if (accept) begin
                if (!op_mem) begin
                    // Unused op encoding falls through here as a plain forward.
                    rf_we_o    <= ex_reg_we_i && (ex_rd_addr_i != 5'd0);
                    rf_waddr_o <= ex_rd_addr_i;
                    rf_wdata_o <= 32'(ex_addr_i);
                end else if (op_mis) begin
                    misaligned_o <= 1'b1;
                end else begin
                    addr_q     <= {ex_addr_i[AW-1:2], 2'b00};
                    we_q       <= op_store;
                    be_q       <= be_new;
                    wdata_q    <= st_data_new;
                    size_q     <= ex_size_i;
                    offset_q   <= ex_addr_i[1:0];
                    unsigned_q <= ex_unsigned_i;
                    rd_q       <= ex_rd_addr_i;
                    load_q     <= op_load;
                end
            end

            if (state_q == WAIT_RVALID && data_rvalid_i) begin
                if (data_err_i) begin
                    lsu_err_o <= 1'b1;
                end else if (load_q && rd_q != 5'd0) begin
                    rf_we_o    <= 1'b1;
                    rf_waddr_o <= rd_q;
                    rf_wdata_o <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: forwarding, loads, stores, misalignment, bus error, mid-transaction reset.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: bus grant/rvalid are driven by hand in each scenario.
module tb_mem_stage;
    import milano_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [1:0]  ex_mem_op_i;
    logic [1:0]  ex_size_i;
    logic        ex_unsigned_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_reg_we_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        lsu_err_o;
    logic        misaligned_o;

    int vectors;
    int miscompares;

    mem_stage #(.AW(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_mem_op_i   (ex_mem_op_i),
        .ex_size_i     (ex_size_i),
        .ex_unsigned_i (ex_unsigned_i),
        .ex_addr_i     (ex_addr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_reg_we_i   (ex_reg_we_i),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .lsu_err_o     (lsu_err_o),
        .misaligned_o  (misaligned_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic we);
        ex_valid_i    = 1'b1;
        ex_mem_op_i   = op;
        ex_size_i     = size;
        ex_unsigned_i = uns;
        ex_addr_i     = addr;
        ex_wdata_i    = wdata;
        ex_rd_addr_i  = rd;
        ex_reg_we_i   = we;
    endtask

    task automatic test_reset;
        #1;
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ex_ready_o); end
        vectors++; if (data_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", data_req_o); end
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got=%b exp=0", rf_we_o); end
        vectors++; if (lsu_err_o !== 1'b0 || misaligned_o !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got=%b%b exp=00", lsu_err_o, misaligned_o); end
        vectors++; if (data_be_o !== 4'b0 || data_addr_o !== 32'b0 || rf_wdata_o !== 32'b0) begin miscompares++; $display("FAIL reset_regs be=%h addr=%h rfw=%h exp=0", data_be_o, data_addr_o, rf_wdata_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_mem_none;
        @(negedge clk_i);
        drive_op(MEM_NONE, SZ_W, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b1) begin miscompares++; $display("FAIL none_we got=%b exp=1", rf_we_o); end
        vectors++; if (rf_waddr_o !== 5'd5) begin miscompares++; $display("FAIL none_waddr got=%0d exp=5", rf_waddr_o); end
        vectors++; if (rf_wdata_o !== 32'h1234_5678) begin miscompares++; $display("FAIL none_wdata got=%h exp=12345678", rf_wdata_o); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL none_ready got=%b exp=1", ex_ready_o); end
        // back-to-back, rd=0 must not write
        drive_op(MEM_NONE, SZ_W, 1'b0, 32'hDEAD_0000, 32'h0, 5'd0, 1'b1);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL none_rd0_we got=%b exp=0", rf_we_o); end
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL none_idle_we got=%b exp=0", rf_we_o); end
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        drive_op(MEM_LOAD, SZ_B, uns, 32'h0000_0103, 32'h0, 5'd10, 1'b1);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        vectors++; if (data_req_o !== 1'b1) begin miscompares++; $display("FAIL lb_req got=%b exp=1", data_req_o); end
        vectors++; if (data_addr_o !== 32'h0000_0100) begin miscompares++; $display("FAIL lb_addr got=%h exp=00000100", data_addr_o); end
        vectors++; if (data_be_o !== 4'b1000 || data_we_o !== 1'b0) begin miscompares++; $display("FAIL lb_be_we got=%b/%b exp=1000/0", data_be_o, data_we_o); end
        vectors++; if (ex_ready_o !== 1'b0) begin miscompares++; $display("FAIL lb_ready_gnt got=%b exp=0", ex_ready_o); end
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        vectors++; if (data_req_o !== 1'b0 || ex_ready_o !== 1'b0) begin miscompares++; $display("FAIL lb_wait_rvalid req=%b rdy=%b exp=0/0", data_req_o, ex_ready_o); end
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h80AA_BBCC;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        vectors++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd10) begin miscompares++; $display("FAIL lb_wb we=%b waddr=%0d exp=1/10", rf_we_o, rf_waddr_o); end
        vectors++; if (rf_wdata_o !== exp) begin miscompares++; $display("FAIL lb_data uns=%b got=%h exp=%h", uns, rf_wdata_o, exp); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL lb_ready_after got=%b exp=1", ex_ready_o); end
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL lb_we_pulse got=%b exp=0", rf_we_o); end
    endtask

    task automatic test_store_half;
        drive_op(MEM_STORE, SZ_H, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 5'd7, 1'b0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (data_req_o !== 1'b1) begin miscompares++; $display("FAIL sh_req cyc=%0d got=%b exp=1", c, data_req_o); end
            vectors++; if (data_addr_o !== 32'h0000_0200 || data_be_o !== 4'b1100 || data_we_o !== 1'b1) begin
                miscompares++; $display("FAIL sh_addr_be cyc=%0d addr=%h be=%b we=%b exp=00000200/1100/1", c, data_addr_o, data_be_o, data_we_o); end
            vectors++; if (data_wdata_o !== 32'hBEEF_BEEF) begin miscompares++; $display("FAIL sh_wdata cyc=%0d got=%h exp=beefbeef", c, data_wdata_o); end
            data_gnt_i = (c == 3);
            @(negedge clk_i);
        end
        data_gnt_i = 1'b0;
        vectors++; if (data_req_o !== 1'b0) begin miscompares++; $display("FAIL sh_req_drop got=%b exp=0", data_req_o); end
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL sh_no_rf got=%b exp=0", rf_we_o); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL sh_ready got=%b exp=1", ex_ready_o); end
    endtask

    task automatic test_misaligned;
        drive_op(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0301, 32'h0, 5'd4, 1'b1);
        @(negedge clk_i);
        vectors++; if (misaligned_o !== 1'b1) begin miscompares++; $display("FAIL mis_lw_pulse got=%b exp=1", misaligned_o); end
        vectors++; if (data_req_o !== 1'b0 || ex_ready_o !== 1'b1 || rf_we_o !== 1'b0) begin
            miscompares++; $display("FAIL mis_lw_side req=%b rdy=%b we=%b exp=0/1/0", data_req_o, ex_ready_o, rf_we_o); end
        drive_op(MEM_STORE, SZ_H, 1'b0, 32'h0000_0201, 32'h1, 5'd0, 1'b0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        vectors++; if (misaligned_o !== 1'b1 || data_req_o !== 1'b0) begin miscompares++; $display("FAIL mis_sh mis=%b req=%b exp=1/0", misaligned_o, data_req_o); end
        // stray rvalid while idle must be ignored
        data_rvalid_i = 1'b1;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        vectors++; if (misaligned_o !== 1'b0 || data_req_o !== 1'b0) begin miscompares++; $display("FAIL mis_end mis=%b req=%b exp=0/0", misaligned_o, data_req_o); end
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b0 || ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL stray_rvalid we=%b rdy=%b exp=0/1", rf_we_o, ex_ready_o); end
    endtask

    task automatic test_bus_error;
        drive_op(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0400, 32'h0, 5'd9, 1'b1);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        data_rdata_i  = 32'h5555_5555;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        vectors++; if (lsu_err_o !== 1'b1) begin miscompares++; $display("FAIL err_pulse got=%b exp=1", lsu_err_o); end
        vectors++; if (rf_we_o !== 1'b0) begin miscompares++; $display("FAIL err_no_rf got=%b exp=0", rf_we_o); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL err_idle got=%b exp=1", ex_ready_o); end
        @(negedge clk_i);
        vectors++; if (lsu_err_o !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle got=%b exp=0", lsu_err_o); end
    endtask

    task automatic test_reset_mid;
        drive_op(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        vectors++; if (data_req_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_before got=%b exp=1", data_req_o); end
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (data_req_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_async got=%b exp=0", data_req_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        vectors++; if (ex_ready_o !== 1'b1 || data_req_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle rdy=%b req=%b exp=1/0", ex_ready_o, data_req_o); end
        drive_op(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0504, 32'h0, 5'd3, 1'b1);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        vectors++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_0504 || data_be_o !== 4'hF) begin
            miscompares++; $display("FAIL rstmid_lw_req req=%b addr=%h be=%h exp=1/00000504/f", data_req_o, data_addr_o, data_be_o); end
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        vectors++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL rstmid_lw_wb we=%b waddr=%0d data=%h exp=1/3/cafef00d", rf_we_o, rf_waddr_o, rf_wdata_o); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_ni        = 1'b0;
        ex_valid_i    = 1'b0;
        ex_mem_op_i   = 2'b0;
        ex_size_i     = 2'b0;
        ex_unsigned_i = 1'b0;
        ex_addr_i     = 32'h0;
        ex_wdata_i    = 32'h0;
        ex_rd_addr_i  = 5'd0;
        ex_reg_we_i   = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        data_err_i    = 1'b0;

        test_reset();
        test_mem_none();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_misaligned();
        test_bus_error();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
